load_store_unit: RTL and testbench

//  Datapath-side initiator for the byte-addressable, big-endian 1Kx32 data memory.

---
 rtl/mips_ls_pkg.sv | 40 ++++
 rtl/ls_lane_unit.sv | 83 ++++++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ls_pkg.sv
// Shared encodings for the MIPS load/store unit: opcode values, FSM states
// and small opcode-classification helpers.
package mips_ls_pkg;

    localparam int ADDR_W_DEF = 12;

    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0011,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1011
    } ls_op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR       = 3'd2,
        DONE     = 3'd3,
        ERR_DONE = 3'd4
    } ls_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            LB, LH, LW, LBU, LHU, SB, SH, SW: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Every legal load has opcode bit 3 clear, every legal store has it set.
    function automatic logic op_is_load(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/ls_lane_unit.sv
// Combinational big-endian lane logic: load extraction/extension, sub-word
// store merge into a read word, and alignment check for the given opcode.
module ls_lane_unit
    import mips_ls_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_val_o,
    output logic [31:0] store_word_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half; byte lane 0 is the most significant.
    always_comb begin
        byte_s = 8'h00;
        case (lane_i)
            2'd0:    byte_s = mem_word_i[31:24];
            2'd1:    byte_s = mem_word_i[23:16];
            2'd2:    byte_s = mem_word_i[15:8];
            2'd3:    byte_s = mem_word_i[7:0];
            default: byte_s = 8'h00;
        endcase
        if (lane_i[1]) begin
            half_s = mem_word_i[15:0];
        end else begin
            half_s = mem_word_i[31:16];
        end
    end

    // Load result with sign or zero extension.
    always_comb begin
        load_val_o = 32'h0000_0000;
        case (op_i)
            LB:      load_val_o = {{24{byte_s[7]}}, byte_s};
            LBU:     load_val_o = {24'h00_0000, byte_s};
            LH:      load_val_o = {{16{half_s[15]}}, half_s};
            LHU:     load_val_o = {16'h0000, half_s};
            LW:      load_val_o = mem_word_i;
            default: load_val_o = 32'h0000_0000;
        endcase
    end

    // Store word: the addressed lane takes the low bits of the store data.
    always_comb begin
        store_word_o = mem_word_i;
        case (op_i)
            SB: begin
                case (lane_i)
                    2'd0:    store_word_o[31:24] = store_data_i[7:0];
                    2'd1:    store_word_o[23:16] = store_data_i[7:0];
                    2'd2:    store_word_o[15:8]  = store_data_i[7:0];
                    2'd3:    store_word_o[7:0]   = store_data_i[7:0];
                    default: store_word_o        = mem_word_i;
                endcase
            end
            SH: begin
                if (lane_i[1]) begin
                    store_word_o[15:0] = store_data_i[15:0];
                end else begin
                    store_word_o[31:16] = store_data_i[15:0];
                end
            end
            SW:      store_word_o = store_data_i;
            default: store_word_o = mem_word_i;
        endcase
    end

    // Alignment check.
    always_comb begin
        misalign_o = 1'b0;
        case (op_i)
            LH, LHU, SH: misalign_o = lane_i[0];
            LW, SW:      misalign_o = |lane_i;
            default:     misalign_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store initiator for a word-only big-endian data memory; sub-word
// stores are done as read-modify-write, all outputs come straight from flops.
module load_store_unit
    import mips_ls_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [3:0]        ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic [31:0]       rdata,
    output logic              dm_cs,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    ls_state_e         state_q;
    logic [3:0]        op_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cs_q;
    logic              rd_q;
    logic              wr_q;

    logic [3:0]  lane_op_s;
    logic [1:0]  lane_sel_s;
    logic [31:0] load_val_s;
    logic [31:0] store_word_s;
    logic        misalign_s;

    // In IDLE the lane unit checks the incoming request, otherwise the latched one.
    always_comb begin
        if (state_q == IDLE) begin
            lane_op_s  = ls_op;
            lane_sel_s = ls_addr[1:0];
        end else begin
            lane_op_s  = op_q;
            lane_sel_s = lane_q;
        end
    end

    ls_lane_unit u_lane (
        .op_i         (lane_op_s),
        .lane_i       (lane_sel_s),
        .mem_word_i   (dm_dout),
        .store_data_i (wdata_q),
        .load_val_o   (load_val_s),
        .store_word_o (store_word_s),
        .misalign_o   (misalign_s)
    );

    // Control FSM with request latches and registered memory/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'h0;
            lane_q  <= 2'd0;
            wdata_q <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            addr_q  <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (req) begin
                        op_q    <= ls_op;
                        lane_q  <= ls_addr[1:0];
                        wdata_q <= ls_wdata;
                        addr_q  <= {ls_addr[ADDR_W-1:2], 2'b00};
                        busy_q  <= 1'b1;
                        if (!op_legal(ls_op) || misalign_s) begin
                            state_q <= ERR_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (ls_op == SW) begin
                            state_q <= WR;
                            data_q  <= ls_wdata;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                        end else begin
                            state_q <= RD;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                RD: begin
                    rd_q <= 1'b0;
                    if (op_is_load(op_q)) begin
                        rdata_q <= load_val_s;
                        state_q <= DONE;
                        cs_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        data_q  <= store_word_s;
                        state_q <= WR;
                        wr_q    <= 1'b1;
                    end
                end
                WR: begin
                    state_q <= DONE;
                    cs_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE, ERR_DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cs_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign addr_err = err_q;
    assign rdata    = rdata_q;
    assign dm_cs    = cs_q;
    assign dm_rd    = rd_q;
    assign dm_wr    = wr_q;
    assign dm_addr  = addr_q;
    assign dm_din   = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench: load_store_unit paired with a 1Kx32 data memory, checked against a
// byte-array reference of memory and a per-opcode rule model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [3:0]  ls_op;
    logic [11:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        busy, done, addr_err;
    logic [31:0] rdata;
    logic        dm_cs, dm_rd, dm_wr;
    logic [11:0] dm_addr;
    logic [31:0] dm_din;
    wire  [31:0] dm_dout;

    logic [31:0] mem [1024];
    logic [7:0]  ref_mem [4096];
    logic [31:0] exp_rdata;
    int          n_checks;
    int          n_pass;

    load_store_unit #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ls_op(ls_op), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .busy(busy), .done(done), .addr_err(addr_err),
        .rdata(rdata), .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_dout = (dm_cs && dm_rd) ? mem[dm_addr[11:2]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (dm_cs && dm_wr) mem[dm_addr[11:2]] <= dm_din;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [11:0] a);
        logic [11:0] w;
        w = {a[11:2], 2'b00};
        return {ref_mem[w], ref_mem[w + 12'd1], ref_mem[w + 12'd2], ref_mem[w + 12'd3]};
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd11};
    endfunction

    function automatic int op_size(input logic [3:0] op);
        case (op[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 10) begin
            @(negedge clk);
            g++;
        end
        check_eq("idle_before_req", {31'd0, busy}, 32'd0);
    endtask

    // One request; inputs are scrambled right after the accept edge.
    task automatic do_op(input logic [3:0] op, input logic [11:0] a, input logic [31:0] wd);
        int  sz, lat, exp_lat;
        bit  err, saw_cs;
        logic [31:0] v;
        sz  = op_size(op);
        err = !is_legal(op) || (a % sz != 0);
        if (err) exp_lat = 1;
        else if (op == 4'd11 || !op[3]) exp_lat = 2;
        else exp_lat = 3;
        wait_idle();
        req = 1'b1; ls_op = op; ls_addr = a; ls_wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; ls_op = 4'($urandom); ls_addr = 12'($urandom); ls_wdata = $urandom;
        lat = 1; saw_cs = dm_cs;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (dm_cs) saw_cs = 1'b1;
        end
        if (!err && !op[3]) begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[a + 12'(i)]);
            if (op == 4'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (op == 4'd1 && v[15]) v = v | 32'hFFFF_0000;
            exp_rdata = v;
        end
        if (!err && op[3]) begin
            for (int i = 0; i < sz; i++) ref_mem[a + 12'(i)] = wd[8*(sz-1-i) +: 8];
        end
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("addr_err", {31'd0, addr_err}, {31'd0, err});
        check_eq("busy_at_done", {31'd0, busy}, 32'd1);
        if (err) check_eq("err_no_mem_cycle", {31'd0, saw_cs}, 32'd0);
        check_eq("rdata", rdata, exp_rdata);
        @(posedge clk); #1;
        check_eq("mem_word", mem[a[11:2]], ref_word(a));
    endtask

    initial begin
        int dones;
        logic [4:0] busy_v;
        n_checks = 0; n_pass = 0; exp_rdata = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        req = 1'b0; ls_op = 4'd0; ls_addr = 12'd0; ls_wdata = 32'd0;
        rst_n = 1'b0;
        #12;
        check_eq("rst_outs", {busy, done, addr_err, dm_cs, dm_rd, dm_wr}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_dm_addr", {20'd0, dm_addr}, 32'd0);
        check_eq("rst_dm_din", dm_din, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int w = 0; w < 16; w++) do_op(4'd11, 12'(w * 4), $urandom);
        for (int w = 0; w < 16; w++) do_op(4'd11, 12'h FC0 + 12'(w * 4), $urandom);

        do_op(4'd11, 12'h010, 32'hDEADBEEF);
        do_op(4'd3,  12'h010, 32'h0);
        check_eq("t1_lw", rdata, 32'hDEADBEEF);

        do_op(4'd11, 12'h010, 32'h11223344);
        do_op(4'd8,  12'h012, 32'h00000080);
        do_op(4'd3,  12'h010, 32'h0);
        check_eq("t2_lw", rdata, 32'h11228044);
        do_op(4'd0,  12'h012, 32'h0);
        check_eq("t2_lb", rdata, 32'hFFFFFF80);
        do_op(4'd4,  12'h012, 32'h0);
        check_eq("t2_lbu", rdata, 32'h00000080);

        do_op(4'd11, 12'h010, 32'h1122F344);
        do_op(4'd1,  12'h012, 32'h0);
        check_eq("t3_lh", rdata, 32'hFFFFF344);
        do_op(4'd5,  12'h012, 32'h0);
        check_eq("t3_lhu", rdata, 32'h0000F344);
        do_op(4'd1,  12'h010, 32'h0);
        check_eq("t3_lh_hi", rdata, 32'h00001122);

        do_op(4'd1,  12'h011, 32'h0);
        do_op(4'd11, 12'h012, 32'h55AA55AA);
        do_op(4'd2,  12'h010, 32'h0);
        check_eq("t4_rdata_kept", rdata, 32'h00001122);

        // req held high: one op per IDLE, next accept right after DONE.
        wait_idle();
        req = 1'b1; ls_op = 4'd8; ls_addr = 12'h012; ls_wdata = 32'h000000A5;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            busy_v[i] = busy;
            dones += int'(done);
        end
        req = 1'b0;
        ref_mem[12'h012] = 8'hA5;
        check_eq("t5_busy_seq", {27'd0, busy_v}, 32'h17);
        check_eq("t5_one_done", 32'(dones), 32'd1);
        for (int i = 0; i < 6 && !done; i++) begin
            @(posedge clk); #1;
        end
        check_eq("t5_second_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        check_eq("t5_mem", mem[12'h010 >> 2], ref_word(12'h010));

        // Reset during the RD cycle of an sh: no write may follow.
        wait_idle();
        req = 1'b1; ls_op = 4'd9; ls_addr = 12'h020; ls_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req = 1'b0;
        check_eq("t6_in_rd", {31'd0, dm_rd}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_outs", {busy, done, addr_err, dm_cs, dm_rd, dm_wr}, 32'd0);
        check_eq("t6_rst_rdata", rdata, 32'd0);
        check_eq("t6_rst_dm", {20'd0, dm_addr} | dm_din, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_mem_unchanged", mem[12'h020 >> 2], ref_word(12'h020));

        do_op(4'd11, 12'hFFC, 32'hCAFEF00D);
        do_op(4'd3,  12'hFFC, 32'h0);
        check_eq("t6_top_word", rdata, 32'hCAFEF00D);

        for (int n = 0; n < 80; n++) begin
            logic [3:0]  op;
            logic [11:0] a;
            logic [3:0]  legal_ops [8];
            legal_ops = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd11};
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            else op = legal_ops[$urandom_range(0, 7)];
            a = {($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00, 6'($urandom)};
            do_op(op, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
